// File: rtl/dp_accum_drain_pkg.sv
// Shared definitions for the sparse dot-product accumulate/drain stages:
// FSM encoding and signed saturation bounds for a given accumulator width.
package dp_accum_drain_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Largest value representable in a w-bit two's-complement word.
    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Smallest value representable in a w-bit two's-complement word.
    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/dp_accum_drain_sat_add_lane.sv
// One accumulator lane: wide signed register, saturating adder and a sticky
// saturation flag. Controls are prioritised clear > load > add.
module sat_add_lane #(
    parameter int DW_DATA = 8,
    parameter int DW_ACC  = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      load,
    input  logic                      add,
    input  logic signed [DW_DATA-1:0] din,
    output logic signed [DW_ACC-1:0]  acc,
    output logic                      sat
);
    import dp_accum_drain_pkg::*;

    localparam logic signed [DW_ACC:0] MAX_V = (DW_ACC + 1)'(sat_max(DW_ACC));
    localparam logic signed [DW_ACC:0] MIN_V = (DW_ACC + 1)'(sat_min(DW_ACC));

    logic signed [DW_ACC-1:0] acc_reg;
    logic                     sat_reg;
    logic signed [DW_ACC:0]   sum_w;
    logic signed [DW_ACC-1:0] acc_next;
    logic                     ovf_next;

    // One guard bit is enough: |din| is always far below the accumulator range.
    assign sum_w = (DW_ACC + 1)'(acc_reg) + (DW_ACC + 1)'(din);

    always_comb begin
        acc_next = sum_w[DW_ACC-1:0];
        ovf_next = 1'b0;
        if (sum_w > MAX_V) begin
            acc_next = MAX_V[DW_ACC-1:0];
            ovf_next = 1'b1;
        end else if (sum_w < MIN_V) begin
            acc_next = MIN_V[DW_ACC-1:0];
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg <= '0;
            sat_reg <= 1'b0;
        end else if (clear) begin
            acc_reg <= '0;
            sat_reg <= 1'b0;
        end else if (load) begin
            // Clear-then-add from zero cannot clamp since DW_ACC > DW_DATA.
            acc_reg <= DW_ACC'(din);
            sat_reg <= 1'b0;
        end else if (add) begin
            acc_reg <= acc_next;
            sat_reg <= sat_reg | ovf_next;
        end
    end

    assign acc = acc_reg;
    assign sat = sat_reg;

endmodule

// File: rtl/dp_accum_drain.sv
// Accumulates N_UNIT-wide partial-result beats per tile, then drains the
// per-lane sums one lane per beat over valid/ready and re-arms.
module dp_accum_drain #(
    parameter int N_UNIT  = 32,
    parameter int DW_DATA = 8,
    parameter int DW_ACC  = 24,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = $clog2((N_UNIT > 2) ? N_UNIT : 2)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_UNIT*DW_DATA-1:0] in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    input  logic                      in_clear,
    output logic                      in_ready,
    output logic [DW_ACC-1:0]         out_data,
    output logic [IDX_W-1:0]          out_idx,
    output logic                      out_sat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          step_cnt
);
    import dp_accum_drain_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_UNIT - 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   step_cnt_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;

    logic signed [DW_ACC-1:0] acc_w [N_UNIT];
    logic [N_UNIT-1:0]        sat_w;

    logic xfer;
    logic drain_hs;
    logic drain_done;
    logic lane_clear;
    logic lane_load;
    logic lane_add;

    assign xfer       = in_ready_reg && in_valid;
    assign drain_hs   = out_valid_reg && out_ready;
    assign drain_done = drain_hs && (idx_reg == LAST_IDX);
    assign lane_clear = (in_ready_reg && in_clear && !in_valid) || drain_done;
    assign lane_load  = xfer && in_clear;
    assign lane_add   = xfer && !in_clear;

    generate
        for (genvar gi = 0; gi < N_UNIT; gi++) begin : g_lane
            sat_add_lane #(
                .DW_DATA(DW_DATA),
                .DW_ACC (DW_ACC)
            ) u_lane (
                .clk  (clk),
                .reset(reset),
                .clear(lane_clear),
                .load (lane_load),
                .add  (lane_add),
                .din  ($signed(in_data[gi*DW_DATA +: DW_DATA])),
                .acc  (acc_w[gi]),
                .sat  (sat_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_ACCUM;
            idx_reg       <= '0;
            step_cnt_reg  <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_ACCUM: begin
                    if (xfer) begin
                        step_cnt_reg <= in_clear ? CNT_W'(1) : step_cnt_reg + CNT_W'(1);
                        if (in_last) begin
                            state_reg     <= ST_DRAIN;
                            idx_reg       <= '0;
                            in_ready_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
                    end else if (in_clear) begin
                        step_cnt_reg <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_hs) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg     <= ST_ACCUM;
                            idx_reg       <= '0;
                            step_cnt_reg  <= '0;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: state_reg <= ST_ACCUM;
            endcase
        end
    end

    // Mux selects only from registers, so no input reaches an output in the same cycle.
    assign out_data  = out_valid_reg ? acc_w[idx_reg] : '0;
    assign out_sat   = out_valid_reg & sat_w[idx_reg];
    assign out_idx   = idx_reg;
    assign out_valid = out_valid_reg;
    assign in_ready  = in_ready_reg;
    assign step_cnt  = step_cnt_reg;

endmodule

// File: tb/tb_dp_accum_drain.sv
// Directed bench for dp_accum_drain: a cycle-by-cycle vector table plus
// hand sequences for drain back-pressure and reset mid-drain.
module tb_dp_accum_drain;

    localparam int N_UNIT  = 4;
    localparam int DW_DATA = 8;
    localparam int DW_ACC  = 10;
    localparam int CNT_W   = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [N_UNIT*DW_DATA-1:0] in_data;
    logic                      in_valid;
    logic                      in_last;
    logic                      in_clear;
    logic                      in_ready;
    logic [DW_ACC-1:0]         out_data;
    logic [1:0]                out_idx;
    logic                      out_sat;
    logic                      out_valid;
    logic                      out_ready;
    logic [CNT_W-1:0]          step_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dp_accum_drain #(
        .N_UNIT (N_UNIT),
        .DW_DATA(DW_DATA),
        .DW_ACC (DW_ACC),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_clear (in_clear),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_sat  (out_sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .step_cnt (step_cnt)
    );

    typedef struct {
        logic [31:0] d;
        logic        v, l, c, r;
        logic        e_rdy, e_ov;
        int          e_idx, e_data;
        logic        e_sat;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c2, input int dd,
                                input logic v, input logic l, input logic c, input logic r,
                                input logic erdy, input logic eov, input int eidx,
                                input int edata, input logic esat, input int ecnt);
        vec_t m;
        m.d = pk(a, b, c2, dd);
        m.v = v; m.l = l; m.c = c; m.r = r;
        m.e_rdy = erdy; m.e_ov = eov; m.e_idx = eidx;
        m.e_data = edata; m.e_sat = esat; m.e_cnt = ecnt;
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int erdy, input int eov, input int eidx,
                             input int edata, input int esat, input int ecnt);
        chk({tag, " in_ready"},  int'(in_ready),          erdy);
        chk({tag, " out_valid"}, int'(out_valid),         eov);
        chk({tag, " out_idx"},   int'(out_idx),           eidx);
        chk({tag, " out_data"},  int'($signed(out_data)), edata);
        chk({tag, " out_sat"},   int'(out_sat),           esat);
        chk({tag, " step_cnt"},  int'(step_cnt),          ecnt);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic v, input logic l,
                         input logic c, input logic r);
        in_data = d; in_valid = v; in_last = l; in_clear = c; out_ready = r;
    endtask

    initial begin
        reset = 1'b0;
        drive(32'h0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Tile A: three {1,2,3,4} beats; in_clear during drain must be ignored.
        tbl.push_back(mk(1,2,3,4, 1,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(1,2,3,4, 1,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(1,2,3,4, 1,1,0,0, 1,0,0,0,0,2));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,0,3,0,3));
        tbl.push_back(mk(0,0,0,0, 0,0,1,1, 0,1,1,6,0,3));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,2,9,0,3));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,3,12,0,3));
        // Partial tile then a standalone clear; following tile must start from zero.
        tbl.push_back(mk(3,3,3,3, 1,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,1,0, 1,0,0,0,0,1));
        // Tile B: {-128,127,-1,0} x4, lane 0 lands exactly on the minimum.
        tbl.push_back(mk(-128,127,-1,0, 1,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(-128,127,-1,0, 1,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(-128,127,-1,0, 1,0,0,0, 1,0,0,0,0,2));
        tbl.push_back(mk(-128,127,-1,0, 1,1,0,0, 1,0,0,0,0,3));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,0,-512,0,4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,1,508,0,4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,2,-4,0,4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,3,0,0,4));
        // Tile C: lane 0 = 127 x5 saturates at 511 with a 10-bit accumulator.
        tbl.push_back(mk(127,0,0,0, 1,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(127,0,0,0, 1,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(127,0,0,0, 1,0,0,0, 1,0,0,0,0,2));
        tbl.push_back(mk(127,0,0,0, 1,0,0,0, 1,0,0,0,0,3));
        tbl.push_back(mk(127,0,0,0, 1,1,0,0, 1,0,0,0,0,4));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,0,511,1,5));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,1,0,0,5));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,2,0,0,5));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,3,0,0,5));
        // Tile D: two beats of 5, then clear+7 as last; sat flag of lane 0 is gone.
        tbl.push_back(mk(5,5,5,5, 1,0,0,0, 1,0,0,0,0,0));
        tbl.push_back(mk(5,5,5,5, 1,0,0,0, 1,0,0,0,0,1));
        tbl.push_back(mk(7,7,7,7, 1,1,1,0, 1,0,0,0,0,2));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,0,7,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,1,7,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,2,7,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,1,3,7,0,1));
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            $display("row %0d: ready=%0d valid=%0d idx=%0d data=%0d sat=%0d cnt=%0d",
                     i, in_ready, out_valid, out_idx, $signed(out_data), out_sat, step_cnt);
            check_all($sformatf("row%0d", i), tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_idx,
                      tbl[i].e_data, tbl[i].e_sat, tbl[i].e_cnt);
            drive(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].c, tbl[i].r);
            step();
        end

        // Back-pressure at idx 1 with a pending upstream beat that must wait.
        drive(pk(10,20,30,40), 1, 1, 0, 0);
        step();
        check_all("bp idx0", 0, 1, 0, 10, 0, 1);
        drive(pk(1,1,1,1), 0, 0, 0, 1);
        step();
        check_all("bp idx1", 0, 1, 1, 20, 0, 1);
        drive(pk(1,1,1,1), 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            $display("hold %0d: ready=%0d idx=%0d data=%0d", i, in_ready, out_idx, $signed(out_data));
            check_all($sformatf("hold%0d", i), 0, 1, 1, 20, 0, 1);
        end
        out_ready = 1'b1;
        step();
        check_all("bp idx2", 0, 1, 2, 30, 0, 1);
        step();
        check_all("bp idx3", 0, 1, 3, 40, 0, 1);
        step();
        check_all("bp rearm", 1, 0, 0, 0, 0, 0);
        step();
        check_all("bp accept", 1, 0, 0, 0, 0, 1);
        drive(pk(0,0,0,0), 0, 0, 1, 0);
        step();
        check_all("bp clear", 1, 0, 0, 0, 0, 0);

        // Reset asserted at drain idx 2 aborts the tile.
        drive(pk(4,4,4,4), 1, 1, 0, 0);
        step();
        drive(pk(0,0,0,0), 0, 0, 0, 1);
        check_all("rst idx0", 0, 1, 0, 4, 0, 1);
        step();
        check_all("rst idx1", 0, 1, 1, 4, 0, 1);
        step();
        check_all("rst idx2", 0, 1, 2, 4, 0, 1);
        reset = 1'b0;
        #1;
        $display("reset mid-drain: ready=%0d valid=%0d idx=%0d", in_ready, out_valid, out_idx);
        check_all("rst async", 1, 0, 0, 0, 0, 0);
        out_ready = 1'b0;
        step();
        reset = 1'b1;
        drive(pk(9,9,9,9), 1, 1, 0, 0);
        step();
        drive(pk(0,0,0,0), 0, 0, 0, 1);
        for (int i = 0; i < N_UNIT; i++) begin
            $display("drain9 %0d: idx=%0d data=%0d", i, out_idx, $signed(out_data));
            check_all($sformatf("nine%0d", i), 0, 1, i, 9, 0, 1);
            step();
        end
        check_all("nine done", 1, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
